ps2_scan_decoder: RTL and testbench

Consumes the byte stream from the PS/2 receive stage (one 8-bit `dato` per `rx_done_tick` pulse). It assembles Set-2 scan-code sequences (plain, `E0`-extended, `F0` break, `E0 F0` extended break) into single key events. Events are buffered in a small first-word-fall-through FIFO, which the game/display logic drains with a read strobe. It sits directly downstream of the PS/2 receiver, in the same `clk_nexys` domain.

---
 rtl/ps2_scan_decoder_if.sv | 27 ++
 rtl/ps2_scan_decoder.sv | 110 +++++++++++
 tb/tb_ps2_scan_decoder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_scan_decoder_if.sv
// Bundle between the PS/2 scan decoder and its producer/consumer: byte input,
// event FIFO head and status.
interface ps2_scan_decoder_if #(
  parameter int unsigned DEPTH_LOG2 = 2
);
  logic                rx_done_tick;
  logic [7:0]          dato;
  logic                rd_en;
  logic                clr_ovf;
  logic [7:0]          evt_code;
  logic                evt_ext;
  logic                evt_break;
  logic                empty;
  logic                full;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;

  modport master (
    output rx_done_tick, dato, rd_en, clr_ovf,
    input  evt_code, evt_ext, evt_break, empty, full, count, overflow
  );

  modport slave (
    input  rx_done_tick, dato, rd_en, clr_ovf,
    output evt_code, evt_ext, evt_break, empty, full, count, overflow
  );
endinterface

// File: rtl/ps2_scan_decoder.sv
// Assembles PS/2 Set-2 scan-code sequences into key events and buffers them
// in a first-word-fall-through FIFO.
module ps2_scan_decoder #(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input logic               clk_nexys,
  input logic               reset_n,
  ps2_scan_decoder_if.slave bus
);
  localparam int unsigned         Depth    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthCnt = (DEPTH_LOG2 + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  state_e                state;
  logic [9:0]            mem [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;

  logic       is_status;
  logic       is_e0;
  logic       is_f0;
  logic       push_req;
  logic       do_push;
  logic       do_pop;
  logic       full;
  logic       empty;
  logic [9:0] push_data;
  logic [9:0] head;

  always_comb begin
    is_status = 1'b0;
    case (bus.dato)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_status = 1'b1;
      default:                                         is_status = 1'b0;
    endcase
    is_e0     = (bus.dato == 8'hE0);
    is_f0     = (bus.dato == 8'hF0);
    push_req  = bus.rx_done_tick && !is_status && !is_e0 && !is_f0;
    push_data = {(state == StExt) || (state == StExtBrk),
                 (state == StBrk) || (state == StExtBrk),
                 bus.dato};
    full      = (count == DepthCnt);
    empty     = (count == '0);
    do_pop    = bus.rd_en && !empty;
    // A full FIFO still accepts the event when the head leaves in the same cycle.
    do_push   = push_req && (!full || do_pop);
  end

  always_ff @(posedge clk_nexys or negedge reset_n) begin
    if (!reset_n) begin
      state <= StIdle;
    end else if (bus.rx_done_tick) begin
      if (is_status) begin
        state <= StIdle;
      end else begin
        case (state)
          StIdle: begin
            if (is_e0)      state <= StExt;
            else if (is_f0) state <= StBrk;
          end
          StExt: begin
            if (is_f0)       state <= StExtBrk;
            else if (!is_e0) state <= StIdle;
          end
          StBrk: begin
            if (is_e0)       state <= StExtBrk;
            else if (!is_f0) state <= StIdle;
          end
          StExtBrk: begin
            if (!is_e0 && !is_f0) state <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk_nexys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(Depth); i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
      // Set takes priority over a simultaneous clear.
      if (push_req && !do_push) overflow <= 1'b1;
      else if (bus.clr_ovf)     overflow <= 1'b0;
    end
  end

  assign head          = mem[rd_ptr];
  assign bus.evt_code  = empty ? 8'h00 : head[7:0];
  assign bus.evt_break = empty ? 1'b0 : head[8];
  assign bus.evt_ext   = empty ? 1'b0 : head[9];
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = count;
  assign bus.overflow  = overflow;
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: a prefix-flag reference model fills an
// expected-event queue; a negedge monitor compares the DUT head and status.
module tb_ps2_scan_decoder;
  localparam int unsigned DL    = 2;
  localparam int unsigned DEPTH = 1 << DL;

  logic clk_nexys = 1'b0;
  logic reset_n   = 1'b0;

  ps2_scan_decoder_if #(.DEPTH_LOG2(DL)) bus ();

  ps2_scan_decoder #(.DEPTH_LOG2(DL)) dut (
    .clk_nexys (clk_nexys),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  always #5 clk_nexys = ~clk_nexys;

  int n_pass  = 0;
  int n_total = 0;

  logic [9:0] exp_q[$];
  bit         m_ext;
  bit         m_brk;
  bit         m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit is_status_byte(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  endfunction

  // Reference: a pending prefix is just two flags; a code byte consumes them.
  always @(posedge clk_nexys or negedge reset_n) begin
    if (!reset_n) begin
      m_ext = 0;
      m_brk = 0;
      m_ovf = 0;
      exp_q.delete();
    end else begin
      bit         pop;
      bit         have_push;
      bit         set_ovf;
      logic [9:0] ev;
      pop       = bus.rd_en && (exp_q.size() > 0);
      have_push = 0;
      set_ovf   = 0;
      ev        = '0;
      if (bus.rx_done_tick) begin
        if (is_status_byte(bus.dato)) begin
          m_ext = 0;
          m_brk = 0;
        end else if (bus.dato == 8'hE0) begin
          m_ext = 1;
        end else if (bus.dato == 8'hF0) begin
          m_brk = 1;
        end else begin
          have_push = 1;
          ev        = {m_ext, m_brk, bus.dato};
          m_ext     = 0;
          m_brk     = 0;
        end
      end
      if (pop) void'(exp_q.pop_front());
      if (have_push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(ev);
        else set_ovf = 1;
      end
      if (set_ovf) m_ovf = 1;
      else if (bus.clr_ovf) m_ovf = 0;
    end
  end

  always @(negedge clk_nexys) begin
    chk("count", 32'(bus.count), 32'(exp_q.size()));
    chk("empty", 32'(bus.empty), 32'(exp_q.size() == 0));
    chk("full", 32'(bus.full), 32'(exp_q.size() == DEPTH));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (exp_q.size() > 0)
      chk("head_evt", 32'({bus.evt_ext, bus.evt_break, bus.evt_code}), 32'(exp_q[0]));
    else
      chk("empty_evt", 32'({bus.evt_ext, bus.evt_break, bus.evt_code}), 32'h0);
  end

  task automatic cycle(input logic t, input logic [7:0] d, input logic rd, input logic clr);
    @(posedge clk_nexys);
    #1;
    bus.rx_done_tick = t;
    bus.dato         = d;
    bus.rd_en        = rd;
    bus.clr_ovf      = clr;
  endtask

  task automatic send(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pop(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] status_tbl [7];
    status_tbl = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    bus.rx_done_tick = 1'b0;
    bus.dato         = 8'h00;
    bus.rd_en        = 1'b0;
    bus.clr_ovf      = 1'b0;
    repeat (3) @(posedge clk_nexys);
    #1 reset_n = 1'b1;
    idle(2);

    // Plain make, then break.
    send(8'h1C); idle(1);
    send(8'hF0); send(8'h1C); idle(2);
    pop(2); idle(1);

    // Extended make and extended break.
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); idle(1);
    pop(3); idle(1);

    // Status bytes are dropped and cancel a pending F0.
    send(8'hAA); send(8'hFA); send(8'hF0); send(8'hFE); send(8'h1C); idle(1);
    pop(2);

    // Overflow on the fifth make, then drain and clear.
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C); idle(2);
    pop(4); idle(1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1); idle(1);

    // Full FIFO with simultaneous push and pop.
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); idle(1);
    cycle(1'b1, 8'h1C, 1'b1, 1'b0); idle(2);
    pop(4); idle(1);

    // Set and clear of overflow in the same cycle: set wins.
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
    cycle(1'b1, 8'h2C, 1'b0, 1'b1); idle(1);
    pop(4); cycle(1'b0, 8'h00, 1'b0, 1'b1); idle(1);

    // Asynchronous reset in the middle of an E0 F0 prefix.
    send(8'h1C); send(8'hE0); send(8'hF0); idle(1);
    #3 reset_n = 1'b0;
    #1;
    chk("rst_empty", 32'(bus.empty), 32'h1);
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_full", 32'(bus.full), 32'h0);
    chk("rst_ovf", 32'(bus.overflow), 32'h0);
    chk("rst_evt", 32'({bus.evt_ext, bus.evt_break, bus.evt_code}), 32'h0);
    @(posedge clk_nexys);
    #1 reset_n = 1'b1;
    send(8'h1C); idle(1);
    pop(1); idle(1);

    // Randomized traffic with back-to-back ticks, random reads and clears.
    for (int i = 0; i < 3000; i++) begin
      logic       t;
      logic [7:0] d;
      int unsigned r;
      t = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 9);
      if (r < 2)      d = 8'hE0;
      else if (r < 4) d = 8'hF0;
      else if (r < 5) d = status_tbl[$urandom_range(0, 6)];
      else            d = 8'($urandom);
      cycle(t, d, ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
    end

    idle(1);
    pop(DEPTH + 2);
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
